mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_wb_reg.sv | 38 +++
 rtl/mem_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: writeback source encoding and MEM stage FSM states.
package cpu_types_pkg;

   // Writeback data source selected in the MEM stage
   typedef enum logic [1:0] {
      MTR_ALU   = 2'b00,
      MTR_LOAD  = 2'b01,
      MTR_NPC   = 2'b10,
      MTR_UPPER = 2'b11
   } memtoreg_t;

   // MEM stage data-cache handshake / halt state
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WAIT   = 2'b01,
      HALTED = 2'b10
   } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with flush, bubble and sticky halt.
module mem_wb_reg
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        flush,
   input  logic        bubble,
   input  logic        regwrite_in,
   input  logic [4:0]  wsel_in,
   input  logic [31:0] wdat_in,
   input  logic        halt_in,
   output logic        wb_regwrite,
   output logic [4:0]  wb_wsel,
   output logic [31:0] wb_wdat,
   output logic        wb_halt
);

   // Flush beats bubble beats capture; wb_halt survives flush and bubble
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_regwrite <= 1'b0;
         wb_wsel     <= '0;
         wb_wdat     <= '0;
         wb_halt     <= 1'b0;
      end else if (flush || bubble) begin
         wb_regwrite <= 1'b0;
         wb_wsel     <= '0;
         wb_wdat     <= '0;
      end else begin
         wb_regwrite <= regwrite_in;
         wb_wsel     <= wsel_in;
         wb_wdat     <= wdat_in;
         if (halt_in) wb_halt <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-cache request/stall FSM, writeback mux, MEM/WB register and
// performance counters.
module mem_stage
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [1:0]       memtoreg_in,
   input  logic             regwrite_in,
   input  logic             dmemREN_in,
   input  logic             dmemWEN_in,
   input  logic             halt_in,
   input  logic [31:0]      aluResult_in,
   input  logic [31:0]      rdat2_in,
   input  logic [31:0]      npc_in,
   input  logic [31:0]      upper16_in,
   input  logic [4:0]       wsel_in,
   input  logic             wb_flush,
   input  logic             dhit,
   input  logic [31:0]      dmemload,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic [31:0]      dmemaddr,
   output logic [31:0]      dmemstore,
   output logic             mem_stall,
   output logic             wb_regwrite,
   output logic [4:0]       wb_wsel,
   output logic [31:0]      wb_wdat,
   output logic             wb_halt,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] retire_count
);

   mem_state_t  state, next_state;
   logic        req_en;
   logic        bubble;
   logic        capture;
   logic [31:0] wdat;

   // Requests are suppressed once halted, and dropped at once while reset is held
   assign req_en    = nRST && (state != HALTED);
   assign dmemREN   = req_en & dmemREN_in;
   assign dmemWEN   = req_en & dmemWEN_in;
   assign dmemaddr  = aluResult_in;
   assign dmemstore = rdat2_in;
   // A load+store pair is one access: a single dhit releases it
   assign mem_stall = (dmemREN | dmemWEN) & ~dhit;

   assign bubble  = (state == HALTED) | mem_stall;
   assign capture = ~wb_flush & ~bubble;

   // FSM state register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   // Next state: halt wins once the current access has completed; flush is ignored
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (halt_in && !mem_stall)        next_state = HALTED;
            else if (mem_stall)               next_state = WAIT;
         end
         WAIT: begin
            if (halt_in && !mem_stall)        next_state = HALTED;
            else if (dhit)                    next_state = IDLE;
         end
         HALTED:                              next_state = HALTED;
         default:                             next_state = IDLE;
      endcase
   end

   // Writeback data source select
   always_comb begin
      wdat = aluResult_in;
      case (memtoreg_t'(memtoreg_in))
         MTR_ALU:   wdat = aluResult_in;
         MTR_LOAD:  wdat = dmemload;
         MTR_NPC:   wdat = npc_in;
         MTR_UPPER: wdat = upper16_in;
         default:   wdat = aluResult_in;
      endcase
   end

   mem_wb_reg u_mem_wb_reg (
      .CLK         (CLK),
      .nRST        (nRST),
      .flush       (wb_flush),
      .bubble      (bubble),
      .regwrite_in (regwrite_in),
      .wsel_in     (wsel_in),
      .wdat_in     (wdat),
      .halt_in     (halt_in),
      .wb_regwrite (wb_regwrite),
      .wb_wsel     (wb_wsel),
      .wb_wdat     (wb_wdat),
      .wb_halt     (wb_halt)
   );

   // Stall and retire performance counters, free-running with wrap
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_count  <= '0;
         retire_count <= '0;
      end else begin
         if (mem_stall)
            stall_count <= stall_count + CNT_W'(1);
         if (capture && (regwrite_in || dmemWEN_in || halt_in))
            retire_count <= retire_count + CNT_W'(1);
      end
   end

endmodule
